dataflow_pingpong_scheduler: RTL and testbench

DATAFLOW_PINGPONG_SCHEDULER -- requirements
Module: dataflow_pingpong_scheduler

---
 rtl/dataflow_pingpong_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_dataflow_pingpong_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_pingpong_scheduler.sv
// Ping-pong scheduler for a producer/consumer dataflow pair sharing two banks.
// Issues start pulses, tracks bank occupancy and flags stalled progress.
module dataflow_pingpong_scheduler #(
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic [CNT_W-1:0] num_frames,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             prod_start,
    input  logic             prod_done,
    output logic             prod_bank,
    output logic             cons_start,
    input  logic             cons_done,
    output logic             cons_bank,
    output logic [1:0]       bank_full,
    output logic             stall_detect,
    output logic [1:0]       stall_origin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_frames;
    logic [CNT_W-1:0] r_prod_issued;
    logic [CNT_W-1:0] r_cons_issued;
    logic             r_prod_busy;
    logic             r_cons_busy;
    logic             r_prod_bank;
    logic             r_cons_bank;
    logic [1:0]       r_bank_full;
    logic [1:0]       w_full_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic             r_stall_detect;
    logic [1:0]       r_stall_origin;
    logic             r_ap_done;

    logic             w_run;
    logic             w_start_acc;
    logic             w_prod_start;
    logic             w_cons_start;
    logic             w_prod_fin;
    logic             w_cons_fin;
    logic             w_prod_last;
    logic             w_cons_last;
    logic             w_event;
    logic             w_stall_hit;

    assign w_run       = (r_state == S_RUN);
    assign w_start_acc = (r_state == S_IDLE) && ap_start;

    // A done only counts while its process is actually busy.
    assign w_prod_fin  = prod_done && r_prod_busy;
    assign w_cons_fin  = cons_done && r_cons_busy;

    // With one frame in flight, issued==frames marks the final completion.
    assign w_prod_last = (r_prod_issued == r_frames);
    assign w_cons_last = (r_cons_issued == r_frames);

    assign w_prod_start = w_run
                        && !r_prod_busy
                        && !r_bank_full[r_prod_bank]
                        && (r_prod_issued < r_frames);

    assign w_cons_start = w_run
                        && !r_cons_busy
                        && r_bank_full[r_cons_bank]
                        && (r_cons_issued < r_frames);

    assign w_event = w_prod_start || w_cons_start
                   || w_prod_fin || w_cons_fin;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    if (num_frames == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_cons_fin && w_cons_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame count latched with an accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frames <= '0;
        end else if (w_start_acc) begin
            r_frames <= num_frames;
        end
    end

    // Producer side: busy flag, issue count and write bank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prod_busy   <= 1'b0;
            r_prod_issued <= '0;
            r_prod_bank   <= 1'b0;
        end else if (w_start_acc) begin
            r_prod_busy   <= 1'b0;
            r_prod_issued <= '0;
            r_prod_bank   <= 1'b0;
        end else if (w_prod_start) begin
            r_prod_busy   <= 1'b1;
            r_prod_issued <= r_prod_issued + ONE;
        end else if (w_prod_fin) begin
            r_prod_busy   <= 1'b0;
            r_prod_bank   <= ~r_prod_bank;
        end
    end

    // Consumer side: busy flag, issue count and read bank.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cons_busy   <= 1'b0;
            r_cons_issued <= '0;
            r_cons_bank   <= 1'b0;
        end else if (w_start_acc) begin
            r_cons_busy   <= 1'b0;
            r_cons_issued <= '0;
            r_cons_bank   <= 1'b0;
        end else if (w_cons_start) begin
            r_cons_busy   <= 1'b1;
            r_cons_issued <= r_cons_issued + ONE;
        end else if (w_cons_fin) begin
            r_cons_busy   <= 1'b0;
            r_cons_bank   <= ~r_cons_bank;
        end
    end

    // Bank occupancy; simultaneous dones always hit opposite banks.
    always_comb begin
        w_full_nxt = r_bank_full;
        if (w_prod_fin) begin
            w_full_nxt[r_prod_bank] = 1'b1;
        end
        if (w_cons_fin) begin
            w_full_nxt[r_cons_bank] = 1'b0;
        end
    end

    // Bank occupancy register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bank_full <= 2'b00;
        end else if (w_start_acc) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= w_full_nxt;
        end
    end

    // Idle-progress counter, saturating at the limit.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (w_run) begin
            if (w_event) begin
                w_stall_cnt_nxt = '0;
            end else if (r_stall_cnt != LIMIT) begin
                w_stall_cnt_nxt = r_stall_cnt + ONE;
            end
        end
    end

    assign w_stall_hit = w_run && !w_event
                       && (w_stall_cnt_nxt == LIMIT)
                       && !r_stall_detect;

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // Sticky stall flag with a snapshot of who was busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_detect <= 1'b0;
            r_stall_origin <= 2'b00;
        end else if (w_start_acc) begin
            r_stall_detect <= 1'b0;
            r_stall_origin <= 2'b00;
        end else if (w_stall_hit) begin
            r_stall_detect <= 1'b1;
            r_stall_origin <= {r_cons_busy, r_prod_busy};
        end
    end

    // Completion pulse, one cycle after the DONE state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ap_done <= 1'b0;
        end else begin
            r_ap_done <= (r_state == S_DONE);
        end
    end

    assign ap_done      = r_ap_done;
    assign ap_idle      = (r_state == S_IDLE);
    assign ap_ready     = w_prod_fin && w_prod_last;
    assign prod_start   = w_prod_start;
    assign prod_bank    = r_prod_bank;
    assign cons_start   = w_cons_start;
    assign cons_bank    = r_cons_bank;
    assign bank_full    = r_bank_full;
    assign stall_detect = r_stall_detect;
    assign stall_origin = r_stall_origin;

endmodule

// File: tb/tb_dataflow_pingpong_scheduler.sv
// Bench for dataflow_pingpong_scheduler: frame-count model plus
// directed scenarios with hand-computed expectations.
module tb_dataflow_pingpong_scheduler;

    localparam int CW  = 16;
    localparam int LIM = 8;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          ap_start   = 1'b0;
    logic [CW-1:0] num_frames = '0;
    logic          prod_done  = 1'b0;
    logic          cons_done  = 1'b0;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic          prod_start;
    logic          prod_bank;
    logic          cons_start;
    logic          cons_bank;
    logic [1:0]    bank_full;
    logic          stall_detect;
    logic [1:0]    stall_origin;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int p_lat  = 5;
    int c_lat  = 5;
    bit p_auto = 1'b1;
    bit c_auto = 1'b1;
    int p_kick = -1;
    int c_kick = -1;

    int   n_ps   = 0;
    int   n_cs   = 0;
    int   n_pd   = 0;
    int   n_done = 0;
    int   rdy_pd = -1;
    logic pb_log [0:255];
    logic cb_log [0:255];

    dataflow_pingpong_scheduler #(
        .CNT_W       (CW),
        .STALL_LIMIT (LIM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .num_frames   (num_frames),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .prod_start   (prod_start),
        .prod_done    (prod_done),
        .prod_bank    (prod_bank),
        .cons_start   (cons_start),
        .cons_done    (cons_done),
        .cons_bank    (cons_bank),
        .bank_full    (bank_full),
        .stall_detect (stall_detect),
        .stall_origin (stall_origin)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Producer/consumer stand-ins: answer a start after a fixed latency,
    // or emit an unsolicited done on a requested cycle.
    initial begin : responder
        int pcd;
        int ccd;
        pcd = -1;
        ccd = -1;
        forever begin
            @(negedge clock);
            if (prod_start === 1'b1 && p_auto) pcd = p_lat;
            if (cons_start === 1'b1 && c_auto) ccd = c_lat;
            @(posedge clock);
            #1;
            if (pcd > 0) pcd--;
            if (ccd > 0) ccd--;
            prod_done = (pcd == 0) || (cyc == p_kick);
            cons_done = (ccd == 0) || (cyc == c_kick);
            if (pcd == 0) pcd = -1;
            if (ccd == 0) ccd = -1;
        end
    end

    // Event log used by the directed scenarios.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (prod_start === 1'b1) begin
                if (n_ps < 256) pb_log[n_ps] = prod_bank;
                n_ps++;
            end
            if (cons_start === 1'b1) begin
                if (n_cs < 256) cb_log[n_cs] = cons_bank;
                n_cs++;
            end
            if (prod_done === 1'b1) n_pd++;
            if (ap_ready === 1'b1) rdy_pd = n_pd;
            if (ap_done === 1'b1) n_done++;
        end
    end

    // Model: frames produced/consumed so far determine banks and occupancy.
    initial begin : model
        int ph;
        int mf;
        int mp;
        int mc;
        int idle;
        bit pb;
        bit cb;
        bit ms;
        bit dp;
        bit dp_n;
        bit pd;
        bit cd;
        bit ev;
        bit e_ps;
        bit e_cs;
        bit e_rdy;
        logic [1:0]  mo;
        logic [1:0]  e_full;
        logic [11:0] e_v;
        logic [11:0] a_v;
        ph = 0; mf = 0; mp = 0; mc = 0; idle = 0;
        pb = 0; cb = 0; ms = 0; dp = 0; mo = 2'b00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                ph = 0; mf = 0; mp = 0; mc = 0; idle = 0;
                pb = 0; cb = 0; ms = 0; dp = 0; mo = 2'b00;
            end
            e_ps  = (ph == 1) && !pb && (mp - mc < 2) && (mp < mf);
            e_cs  = (ph == 1) && !cb && (mp > mc);
            e_rdy = (ph == 1) && (prod_done === 1'b1) && pb
                  && (mp + 1 == mf);
            e_full = 2'b00;
            for (int k = mc; k < mp; k++) e_full[k % 2] = 1'b1;
            e_v = {ph == 0, dp, e_rdy, e_ps, mp[0], e_cs, mc[0],
                   e_full, ms, mo};
            a_v = {ap_idle, ap_done, ap_ready, prod_start, prod_bank,
                   cons_start, cons_bank, bank_full, stall_detect,
                   stall_origin};
            check($sformatf("outputs@%0d", cyc), 32'(a_v), 32'(e_v));
            if (reset) begin
                dp_n = (ph == 2);
                if (ph == 0) begin
                    if (ap_start === 1'b1) begin
                        mf = int'(num_frames);
                        mp = 0; mc = 0; idle = 0;
                        pb = 0; cb = 0; ms = 0; mo = 2'b00;
                        ph = (mf == 0) ? 2 : 1;
                    end
                end else if (ph == 2) begin
                    ph = 0;
                end else begin
                    pd = (prod_done === 1'b1) && pb;
                    cd = (cons_done === 1'b1) && cb;
                    ev = e_ps || e_cs || pd || cd;
                    if (e_ps) pb = 1;
                    if (e_cs) cb = 1;
                    if (pd) begin
                        pb = 0;
                        mp++;
                    end
                    if (cd) begin
                        cb = 0;
                        mc++;
                        if (mc == mf) ph = 2;
                    end
                    if (ev) begin
                        idle = 0;
                    end else begin
                        if (idle < LIM) idle++;
                        if (idle == LIM && !ms) begin
                            ms = 1;
                            mo = {cb, pb};
                        end
                    end
                end
                dp = dp_n;
            end
        end
    end

    task automatic start_run(input int n, output int c0);
        ap_start   = 1'b1;
        num_frames = CW'(n);
        c0 = cyc;
        step();
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            if (ap_done === 1'b1) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  c;
        int  b_ps;
        int  b_cs;
        int  b_pd;
        int  b_done;
        int  k;
        bit  seen;

        #1 reset = 1'b0;
        #2;
        check("reset_idle", 32'(ap_idle), 32'd1);
        check("reset_outs", 32'({ap_done, ap_ready, prod_start,
              cons_start, prod_bank, cons_bank, bank_full,
              stall_detect, stall_origin}), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();

        // Four frames, equal latencies; dones coincide mid-run.
        p_lat = 5; c_lat = 5; p_auto = 1; c_auto = 1;
        b_ps = n_ps; b_cs = n_cs; b_pd = n_pd; b_done = n_done;
        start_run(4, c);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (prod_done === 1'b1 && cons_done === 1'b1) seen = 1'b1;
        end
        check("A_both_seen", 32'(seen), 32'd1);
        check("A_pre_full", 32'(bank_full), 32'h1);
        check("A_pre_pbank", 32'(prod_bank), 32'd1);
        check("A_pre_cbank", 32'(cons_bank), 32'd0);
        @(negedge clock);
        check("A_post_full", 32'(bank_full), 32'h2);
        check("A_post_pbank", 32'(prod_bank), 32'd0);
        check("A_post_cbank", 32'(cons_bank), 32'd1);
        wait_done(60, "A_done_seen");
        check("A_prod_starts", 32'(n_ps - b_ps), 32'd4);
        check("A_cons_starts", 32'(n_cs - b_cs), 32'd4);
        check("A_prod_banks", 32'({pb_log[b_ps], pb_log[b_ps+1],
              pb_log[b_ps+2], pb_log[b_ps+3]}), 32'h5);
        check("A_cons_banks", 32'({cb_log[b_cs], cb_log[b_cs+1],
              cb_log[b_cs+2], cb_log[b_cs+3]}), 32'h5);
        check("A_ready_on_4th", 32'(rdy_pd - b_pd), 32'd4);
        check("A_done_once", 32'(n_done - b_done), 32'd1);
        check("A_idle_back", 32'(ap_idle), 32'd1);

        // Slow consumer: producer fills both banks, then waits.
        p_lat = 2; c_lat = 20;
        b_ps = n_ps; b_done = n_done;
        start_run(3, c);
        p_kick = c + 10;
        repeat (2) step();
        ap_start = 1'b1;
        num_frames = CW'(9);
        step();
        ap_start = 1'b0;
        num_frames = CW'(3);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (cons_done === 1'b1) seen = 1'b1;
        end
        check("B_cdone_seen", 32'(seen), 32'd1);
        check("B_full_both", 32'(bank_full), 32'h3);
        check("B_ps_held", 32'(n_ps - b_ps), 32'd2);
        @(negedge clock);
        check("B_ps_resume", 32'(prod_start), 32'd1);
        check("B_ps_bank", 32'(prod_bank), 32'd0);
        wait_done(80, "B_done_seen");
        check("B_prod_starts", 32'(n_ps - b_ps), 32'd3);
        check("B_done_once", 32'(n_done - b_done), 32'd1);

        // Zero frames: straight to completion.
        b_ps = n_ps; b_cs = n_cs;
        start_run(0, c);
        @(negedge clock);
        check("Z_done_early", 32'(ap_done), 32'd0);
        @(negedge clock);
        check("Z_done_at_2", 32'(ap_done), 32'd1);
        check("Z_done_delay", 32'(cyc - c), 32'd2);
        @(negedge clock);
        check("Z_done_pulse", 32'(ap_done), 32'd0);
        check("Z_no_starts", 32'((n_ps - b_ps) + (n_cs - b_cs)), 32'd0);
        step();

        // Consumer never answers: stall is flagged, late dones still land.
        p_lat = 2; c_auto = 0;
        b_done = n_done;
        start_run(2, c);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (stall_detect === 1'b1) seen = 1'b1;
        end
        check("S_seen", 32'(seen), 32'd1);
        check("S_when", 32'(cyc - c), 32'd15);
        check("S_origin", 32'(stall_origin), 32'h2);
        step();
        c_kick = cyc + 2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (cons_start === 1'b1) seen = 1'b1;
        end
        check("S_cons_restart", 32'(seen), 32'd1);
        step();
        c_kick = cyc + 2;
        wait_done(20, "S_done_seen");
        check("S_sticky", 32'(stall_detect), 32'd1);
        check("S_done_once", 32'(n_done - b_done), 32'd1);

        // Reset in the middle of frame 2, then a clean rerun.
        c_auto = 1; p_lat = 5; c_lat = 5;
        start_run(4, c);
        k = 1;
        for (int i = 0; i < 40 && k < 2; i++) begin
            @(negedge clock);
            if (prod_start === 1'b1) k++;
        end
        check("R_frame2", 32'(k), 32'd2);
        step();
        step();
        b_done = n_done;
        reset = 1'b0;
        #1;
        check("R_idle", 32'(ap_idle), 32'd1);
        check("R_outs", 32'({ap_done, ap_ready, prod_start, cons_start,
              prod_bank, cons_bank, bank_full, stall_detect,
              stall_origin}), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (12) step();
        check("R_no_done", 32'(n_done - b_done), 32'd0);
        start_run(2, c);
        wait_done(60, "R_fresh_done");
        check("R_fresh_once", 32'(n_done - b_done), 32'd1);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
